// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of pending stores. It drains into the data
// memory port whenever memory is not busy. A combinational load lookup
// forwards data from pending stores, or flags a conflict.
// Define STORE_BUFFER_FWD_EN to build with store-to-load forwarding. Without
// it, any overlap between a load and a pending store raises ld_conflict.
module store_buffer #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDRESS_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0]    st_data,
    input  logic                     st_byte,
    input  logic                     ld_valid,
    input  logic [ADDRESS_WIDTH-1:0] ld_addr,
    input  logic                     ld_byte,
    output logic                     ld_hit,
    output logic [DATA_WIDTH-1:0]    ld_data,
    output logic                     ld_conflict,
    input  logic                     mem_busy,
    output logic                     mem_we,
    output logic                     mem_byteop,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     flush,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDRESS_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0]    r_data [DEPTH];
    logic                     r_byte [DEPTH];
    logic [PTR_W-1:0]         r_head;
    logic [PTR_W-1:0]         r_tail;
    logic [CNT_W-1:0]         r_count;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_hit;
    logic                     w_conflict;
    logic [DATA_WIDTH-1:0]    w_fwd_data;
    logic [PTR_W-1:0]         w_idx;
    logic                     w_overlap;
`ifdef STORE_BUFFER_FWD_EN
    logic [DATA_WIDTH-1:0]    w_shift;
`endif

    // Handshake and drain decode. A full buffer refuses a store even when
    // it pops in the same cycle.
    always_comb begin
        st_ready = !rst && !flush && (r_count < CNT_W'(DEPTH));
        mem_we   = !rst && (r_count != '0) && !mem_busy;
        w_push   = st_valid && st_ready;
        w_pop    = mem_we;
    end

    // Memory port is fed from the head entry and forced to zero during reset.
    always_comb begin
        mem_addr   = rst ? '0   : r_addr[r_head];
        mem_wdata  = rst ? '0   : r_data[r_head];
        mem_byteop = rst ? 1'b0 : r_byte[r_head];
        empty      = rst || (r_count == '0);
        count      = r_count;
    end

    // Pointer and occupancy state. Only this state is reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Entry payload is written on push and is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
            r_byte[r_tail] <= st_byte;
        end
    end

    // Load lookup walks oldest to youngest so the youngest overlap wins.
    // An entry pushed this cycle is not stored yet, so it is never seen.
    always_comb begin
        w_hit      = 1'b0;
        w_conflict = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        w_overlap  = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
        w_shift    = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            w_idx     = r_head + PTR_W'(i);
            w_overlap = (r_byte[w_idx] && ld_byte) ?
                        (r_addr[w_idx] == ld_addr) :
                        (r_addr[w_idx][ADDRESS_WIDTH-1:2] == ld_addr[ADDRESS_WIDTH-1:2]);
            if (ld_valid && !rst && (CNT_W'(i) < r_count) && w_overlap) begin
`ifdef STORE_BUFFER_FWD_EN
                if (!ld_byte && r_byte[w_idx]) begin
                    // A word load cannot be assembled from a single pending byte.
                    w_hit      = 1'b0;
                    w_conflict = 1'b1;
                    w_fwd_data = '0;
                end else begin
                    w_hit      = 1'b1;
                    w_conflict = 1'b0;
                    if (!ld_byte) begin
                        w_fwd_data = r_data[w_idx];
                    end else if (r_byte[w_idx]) begin
                        w_fwd_data = DATA_WIDTH'(r_data[w_idx][7:0]);
                    end else begin
                        // Big-endian lane select: offset 0 is the top byte.
                        w_shift    = r_data[w_idx] >>
                                     (DATA_WIDTH - 8 - 8 * int'(ld_addr[1:0]));
                        w_fwd_data = DATA_WIDTH'(w_shift[7:0]);
                    end
                end
`else
                w_hit      = 1'b0;
                w_conflict = 1'b1;
                w_fwd_data = '0;
`endif
            end
        end
    end

    // Lookup results go straight out as combinational outputs.
    always_comb begin
        ld_hit      = w_hit;
        ld_conflict = w_conflict;
        ld_data     = w_fwd_data;
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_store_buffer;

    localparam int DEPTH = 4;
`ifdef STORE_BUFFER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_byte = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        ld_byte = 1'b0;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_conflict;
    logic        mem_busy = 1'b1;
    logic        mem_we;
    logic        mem_byteop;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        flush = 1'b0;
    logic        empty;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        b;
    } ent_t;

    ent_t        q[$];
    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];

    store_buffer #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .DEPTH        (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_byte    (st_byte),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_byte    (ld_byte),
        .ld_hit     (ld_hit),
        .ld_data    (ld_data),
        .ld_conflict(ld_conflict),
        .mem_busy   (mem_busy),
        .mem_we     (mem_we),
        .mem_byteop (mem_byteop),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .flush      (flush),
        .empty      (empty),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference lookup: youngest pending store that overlaps decides.
    function automatic void model_ld(output logic h, output logic c, output logic [31:0] d);
        logic ov;
        h = 1'b0;
        c = 1'b0;
        d = '0;
        if (rst || !ld_valid) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            ov = (q[i].b && ld_byte) ? (q[i].addr == ld_addr) :
                                       (q[i].addr[31:2] == ld_addr[31:2]);
            if (ov) begin
                if (!FWD || (!ld_byte && q[i].b)) begin
                    c = 1'b1;
                end else begin
                    h = 1'b1;
                    if (!ld_byte)  d = q[i].data;
                    else if (q[i].b) d = {24'b0, q[i].data[7:0]};
                    else d = (q[i].data >> (24 - 8 * int'(ld_addr[1:0]))) & 32'hFF;
                end
                return;
            end
        end
    endfunction

    // Model state update at the clock edge, cleared asynchronously by reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            automatic bit do_pop  = (q.size() != 0) && !mem_busy;
            automatic bit do_push = st_valid && !flush && (q.size() < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{addr: st_addr, data: st_data, b: st_byte});
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        logic        eh, ec;
        logic [31:0] ed;
        logic        exp_we;
        model_ld(eh, ec, ed);
        exp_we = !rst && (q.size() != 0) && !mem_busy;
        chk("count", 32'(count), rst ? 32'd0 : 32'(q.size()));
        chk("empty", 32'(empty), (rst || q.size() == 0) ? 32'd1 : 32'd0);
        chk("st_ready", 32'(st_ready), 32'(!rst && !flush && q.size() < DEPTH));
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("ld_hit", 32'(ld_hit), 32'(eh));
        chk("ld_conflict", 32'(ld_conflict), 32'(ec));
        chk("ld_data", ld_data, ed);
        if (exp_we) begin
            chk("mem_addr", mem_addr, q[0].addr);
            chk("mem_wdata", mem_wdata, q[0].data);
            chk("mem_byteop", 32'(mem_byteop), 32'(q[0].b));
        end
        if (rst) begin
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
            chk("rst_mem_byteop", 32'(mem_byteop), 32'd0);
        end
        if (mem_we) begin
            wlog_addr.push_back(mem_addr);
            wlog_data.push_back(mem_wdata);
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic b);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_byte  = b;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (st_ready) break;
        end
        chk("push_ready", 32'(st_ready), 32'd1);
        @(posedge clk);
        #1;
        st_valid = 1'b0;
    endtask

    // Directed load with the forwarding-build expectation; the plain build
    // turns any overlap into a conflict with no data.
    task automatic load(input string name, input logic [31:0] a, input logic b,
                        input logic fh, input logic fc, input logic [31:0] fd);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_byte  = b;
        @(negedge clk);
        chk({name, "_hit"}, 32'(ld_hit), FWD ? 32'(fh) : 32'd0);
        chk({name, "_conflict"}, 32'(ld_conflict), FWD ? 32'(fc) : 32'(fh | fc));
        chk({name, "_data"}, ld_data, FWD ? fd : 32'd0);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        flush    = 1'b1;
        mem_busy = 1'b0;
        @(negedge clk);
        chk("flush_ready", 32'(st_ready), 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (empty) break;
            @(negedge clk);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        mem_busy = 1'b1;
    endtask

    initial begin
        int start;
        int n;

        // Reset state
        @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(st_ready), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill while memory is busy, then drain in order on consecutive cycles
        for (int i = 0; i < 4; i++) push(32'h10000 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
        @(negedge clk);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_ready", 32'(st_ready), 32'd0);
        @(posedge clk);
        #1;
        mem_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_we", 32'(mem_we), 32'd1);
            chk("drain_addr", mem_addr, 32'h10000 + 32'(4 * i));
        end
        @(negedge clk);
        chk("drained_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        mem_busy = 1'b1;

        // Byte load from a pending word store
        push(32'h10000, 32'hAABBCCDD, 1'b0);
        load("bload_word", 32'h10002, 1'b1, 1'b1, 1'b0, 32'h000000CC);
        load("miss", 32'h20000, 1'b0, 1'b0, 1'b0, 32'h0);
        drain();

        // Byte then word: the younger word store wins
        push(32'h10001, 32'h55, 1'b1);
        push(32'h10000, 32'h11223344, 1'b0);
        load("wload_young_word", 32'h10000, 1'b0, 1'b1, 1'b0, 32'h11223344);
        load("bload_young_word", 32'h10001, 1'b1, 1'b1, 1'b0, 32'h00000022);
        drain();

        // Word then byte: the younger byte store blocks a word load
        push(32'h10000, 32'h11223344, 1'b0);
        push(32'h10001, 32'h55, 1'b1);
        load("wload_young_byte", 32'h10000, 1'b0, 1'b0, 1'b1, 32'h0);
        load("bload_same_byte", 32'h10001, 1'b1, 1'b1, 1'b0, 32'h00000055);
        load("bload_other_lane", 32'h10003, 1'b1, 1'b1, 1'b0, 32'h00000044);
        drain();

        // A store being pushed this cycle is invisible to the lookup
        st_valid = 1'b1;
        st_addr  = 32'h30000;
        st_data  = 32'hCAFEF00D;
        st_byte  = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h30000;
        ld_byte  = 1'b0;
        @(negedge clk);
        chk("same_cycle_hit", 32'(ld_hit), 32'd0);
        chk("same_cycle_conflict", 32'(ld_conflict), 32'd0);
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        ld_valid = 1'b0;
        load("next_cycle", 32'h30000, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D);
        drain();

        // Full buffer: a store offered during a pop is refused
        start = wlog_addr.size();
        for (int i = 0; i < 4; i++) push(32'h40000 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0);
        @(negedge clk);
        chk("full_count", 32'(count), 32'd4);
        @(posedge clk);
        #1;
        st_valid = 1'b1;
        st_addr  = 32'h50000;
        st_data  = 32'hDEAD;
        mem_busy = 1'b0;
        @(negedge clk);
        chk("full_pop_ready", 32'(st_ready), 32'd0);
        chk("full_pop_we", 32'(mem_we), 32'd1);
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        mem_busy = 1'b1;
        @(negedge clk);
        chk("full_pop_count", 32'(count), 32'd3);
        drain();
        chk("full_writes", 32'(wlog_addr.size() - start), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("full_order", wlog_addr[start + i], 32'h40000 + 32'(4 * i));

        // Wrap-around over 2*DEPTH stores with intermittent memory stalls
        start = wlog_addr.size();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            mem_busy = (i % 3 == 0);
            push(32'h60000 + 32'(4 * i), 32'hD0 + 32'(i), 1'b0);
        end
        drain();
        chk("wrap_writes", 32'(wlog_addr.size() - start), 32'(2 * DEPTH));
        for (int i = 0; i < 2 * DEPTH; i++) begin
            chk("wrap_addr", wlog_addr[start + i], 32'h60000 + 32'(4 * i));
            chk("wrap_data", wlog_data[start + i], 32'hD0 + 32'(i));
        end

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 4; i++) push(32'h70000 + 32'(4 * i), 32'hE0 + 32'(i), 1'b0);
        @(posedge clk);
        #1;
        mem_busy = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_drain_count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_we", 32'(mem_we), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        n = wlog_addr.size();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_writes", 32'(wlog_addr.size()), 32'(n));
        chk("post_rst_count", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
